melody_sequencer: RTL
=====================

Name: melody_sequencer

Overview:
- Upstream stage of the tone mux in the Pink Panther player. Steps through a note ROM at a fixed tempo and drives the mux's `sel` input with the current note index.
- Also produces rest/articulation gating, a note-start strobe and song status.
- Replaces the static `sel` wiring at the song top level. `sel`/`rest` feed the mux; the top ANDs the mux output with `~rest`.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 16, tempo tick rate; note durations are counted in ticks.
- SONG_LEN, 32, number of ROM entries; address range 0..SONG_LEN-1.
- GAP_TICKS, 1, silent ticks inserted after every note (articulation).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- play, input, 1, level enable; 0 aborts playback.
- loop, input, 1, 1 = restart at entry 0 after the last entry.
- sel, output, 4, note index to the tone mux.
- rest, output, 1, 1 = audio must be silent.
- note_start, output, 1, one-cycle pulse on the first SOUND cycle of each entry.
- busy, output, 1, high in LOAD/SOUND/GAP.
- done, output, 1, high in DONE.

Behaviour:
- One clock. Reset is synchronous and active-high. All state updates on the rising edge of clock.

- Reset values:
  - sel=0, rest=1, note_start=0, busy=0, done=0.
  - address=0, prescaler=0, tick counter=0, state=IDLE.
  - Reset asserted mid-song takes effect at the next edge with exactly these values.

- ROM:
  - Combinational case on address. Entry format {note[3:0], dur[3:0]}.
  - note=4'hF is a rest: sel holds its previous value and rest=1 during SOUND.
  - dur=0 is a terminator: treated as end of song, no sound.
  - Fixed entries: 0=(3,2), 1=(F,1), 2=(5,3). The remaining entries are the melody.

- Prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1 while busy and issues a one-cycle tick at the wrap.
  - Cleared on entry to LOAD, so every note starts phase-aligned.

- State machine:
  - IDLE: rest=1. If play=1, go to LOAD with address=0.
  - LOAD (1 cycle):
    - If dur=0, go to END.
    - Otherwise latch dur into the tick counter and go to SOUND.
    - If note≠F, set sel=note.
  - SOUND:
    - rest = (note==F).
    - note_start=1 in the first cycle only.
    - Decrement the tick counter on each tick. On the tick that reaches 0, go to GAP with the counter set to GAP_TICKS.
    - If GAP_TICKS=0, go directly to ADVANCE.
  - GAP: rest=1. On the tick that reaches 0, go to ADVANCE.
  - ADVANCE (same edge as leaving GAP):
    - If address==SONG_LEN-1, go to END.
    - Otherwise address+1 and go to LOAD.
  - END: if loop=1, set address=0 and go to LOAD; else go to DONE.
  - DONE: rest=1, done=1, busy=0. Stay until play=0, then go to IDLE.

- Priority and boundary cases:
  - play=0 in any busy state: next edge goes to IDLE with rest=1. Priority is reset > play=0 > tick logic.
  - The address never exceeds SONG_LEN-1; there is no wrap except through loop.
  - loop sampled only in END; changing it mid-note has no effect until the end.
  - Entry cost per note is 1 + (dur + GAP_TICKS)·(CLK_HZ/TICK_HZ) cycles.

Test Plan:
- Bench parameters: CLK_HZ=16, TICK_HZ=4 (4 clocks/tick), GAP_TICKS=1.

- Reset with play=1 held → during reset rest=1, sel=0, busy=0. Two cycles after release: note_start=1, sel=3.
- Entry 0 timing → SOUND (rest=0) lasts 8 cycles, then 4 cycles rest=1, then 1 LOAD cycle. The second note_start comes 13 cycles after the first.
- Rest entry 1 → rest=1 for 4+4 cycles with sel still 3. note_start for entry 2 (sel=5) comes 9 cycles after entry 1's note_start. Entry 2 SOUND lasts 12 cycles.
- SONG_LEN=3, loop=0 → after entry 2's gap, done=1, busy=0, rest=1. Dropping play gives IDLE next cycle. Raising play again restarts with sel=3.
- SONG_LEN=3, loop=1 → after entry 2, note_start with sel=3 again; done never asserts.
- play dropped at cycle 5 of entry 0's SOUND → next cycle rest=1, busy=0, no further note_start. Reset asserted mid-GAP → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/melody_sequencer.sv
// Note sequencer for the Pink Panther player: walks the note ROM at a fixed tempo,
// drives the tone mux select and produces rest gating, note-start strobe and song status.
module melody_sequencer #(
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 16,
  parameter int SONG_LEN  = 32,
  parameter int GAP_TICKS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       loop,
  output logic [3:0] sel,
  output logic       rest,
  output logic       note_start,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ADDR_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
  localparam int CNT_W  = (GAP_TICKS > 15) ? $clog2(GAP_TICKS + 1) : 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SOUND = 3'd2,
    S_GAP   = 3'd3,
    S_END   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          sel_q, sel_d;
  logic                is_rest_q, is_rest_d;
  logic                first_q, first_d;

  logic [7:0]          rom_idx;
  logic [7:0]          rom_data;
  logic [3:0]          rom_note;
  logic [3:0]          rom_dur;
  logic                tick;
  logic                advance;
  logic                timing_state;

  // ROM entry format {note, dur}; note F = rest, dur 0 = end of song.
  always_comb begin
    rom_idx = 8'(addr_q);
    case (rom_idx)
      8'd0:    rom_data = 8'h32;
      8'd1:    rom_data = 8'hF1;
      8'd2:    rom_data = 8'h53;
      8'd3:    rom_data = 8'h61;
      8'd4:    rom_data = 8'h73;
      8'd5:    rom_data = 8'hF1;
      8'd6:    rom_data = 8'h31;
      8'd7:    rom_data = 8'h51;
      8'd8:    rom_data = 8'h63;
      8'd9:    rom_data = 8'hF1;
      8'd10:   rom_data = 8'h81;
      8'd11:   rom_data = 8'h71;
      8'd12:   rom_data = 8'h61;
      8'd13:   rom_data = 8'h31;
      8'd14:   rom_data = 8'h51;
      8'd15:   rom_data = 8'h61;
      8'd16:   rom_data = 8'hA4;
      8'd17:   rom_data = 8'h91;
      8'd18:   rom_data = 8'h64;
      8'd19:   rom_data = 8'hF2;
      8'd20:   rom_data = 8'h51;
      8'd21:   rom_data = 8'h41;
      8'd22:   rom_data = 8'h31;
      8'd23:   rom_data = 8'h21;
      8'd24:   rom_data = 8'h11;
      8'd25:   rom_data = 8'h23;
      8'd26:   rom_data = 8'hF1;
      8'd27:   rom_data = 8'h11;
      8'd28:   rom_data = 8'h21;
      8'd29:   rom_data = 8'h11;
      8'd30:   rom_data = 8'h22;
      8'd31:   rom_data = 8'h06;
      default: rom_data = 8'h00;
    endcase
    rom_note = rom_data[7:4];
    rom_dur  = rom_data[3:0];
  end

  assign timing_state = (state_q == S_SOUND) || (state_q == S_GAP);
  assign tick         = timing_state && (presc_q == PRE_W'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      presc_q   <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      is_rest_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      is_rest_q <= is_rest_d;
      first_q   <= first_d;
    end
  end

  // Next state. Dropping play aborts everything except IDLE/DONE handling.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    is_rest_d = is_rest_q;
    advance   = 1'b0;
    if (!play && (state_q == S_LOAD || state_q == S_SOUND ||
                  state_q == S_GAP  || state_q == S_END)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            state_d = S_LOAD;
            addr_d  = '0;
          end
        end
        S_LOAD: begin
          if (rom_dur == 4'd0) begin
            state_d = S_END;
          end else begin
            cnt_d     = CNT_W'(rom_dur);
            is_rest_d = (rom_note == 4'hF);
            if (rom_note != 4'hF) sel_d = rom_note;
            state_d   = S_SOUND;
          end
        end
        S_SOUND: begin
          if (tick) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              if (GAP_TICKS == 0) begin
                advance = 1'b1;
              end else begin
                cnt_d   = CNT_W'(GAP_TICKS);
                state_d = S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) advance = 1'b1;
          end
        end
        S_END: begin
          if (loop) begin
            addr_d  = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (!play) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      // Stepping to the next entry shares the edge that ends the note.
      if (advance) begin
        if (addr_q == ADDR_W'(SONG_LEN - 1)) begin
          state_d = S_END;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LOAD;
        end
      end
    end
  end

  // Prescaler only runs while staying in SOUND/GAP, so each note starts at phase 0.
  always_comb begin
    presc_d = '0;
    if (timing_state && (state_d == S_SOUND || state_d == S_GAP)) begin
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
    end
    first_d = (state_q == S_LOAD) && (state_d == S_SOUND);
  end

  always_comb begin
    sel        = sel_q;
    busy       = (state_q == S_LOAD) || (state_q == S_SOUND) || (state_q == S_GAP);
    done       = (state_q == S_DONE);
    rest       = !((state_q == S_SOUND) && !is_rest_q);
    note_start = (state_q == S_SOUND) && first_q;
    state_dbg  = state_q;
  end

endmodule
